sprite_motion_ctrl: RTL
=======================

// Module: sprite_motion_ctrl
// PURPOSE
//  Generic per-sprite motion engine: fixed-point X/Y integration, gravity, jump, rope climb, screen clamp.
//  Explicit AIR/GROUND/CLIMB state machine. Driven once per frame by startOfFrame.
//  Sits between keyboard/collision logic and the sprite draw block; one instance per movable sprite.
// PARAMETERS
//  FRAC_BITS      6     fractional bits of fixed-point position (1/2^FRAC_BITS px)
//  INIT_X         280   reset X, integer px
//  INIT_Y         185   reset Y, integer px
//  X_SPEED        200   horizontal speed, fp units/frame
//  GRAVITY        10    Y accel in AIR, fp units/frame^2
//  MAX_FALL       230   downward speed cap, fp units/frame
//  JUMP_SPEED     300   initial upward speed on jump
//  CLIMB_SPEED    100   rope climb speed, both directions
//  X_MIN / X_MAX  -9 / 570  inclusive integer-px clamp on topLeftX
//  COYOTE_FRAMES  3     late-jump window, frames (used only with COYOTE_EN)
// PORTS
//  clk           in   1   system clock
//  resetN        in   1   async active-low reset
//  startOfFrame  in   1   one-cycle pulse per frame; all updates happen on this cycle only
//  leftPressed / rightPressed / upPressed / downPressed   in  1 each   key levels
//  collision     in   1   sprite overlaps any object this frame
//  onRope        in   1   sprite overlaps a rope
//  onBlock       in   1   sprite overlaps a solid block
//  HitEdgeCode   in   4   touched sprite edge: [0]=bottom [1]=right [2]=top [3]=left
//  topLeftX      out  11s integer X = x_fp >>> FRAC_BITS (floor)
//  topLeftY      out  11s integer Y = y_fp >>> FRAC_BITS (floor)
//  motionState   out  2   00 AIR, 01 GROUND, 10 CLIMB
//  yVelocity     out  12s current Y speed register, fp units
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame): x_fp=INIT_X<<FRAC_BITS, y_fp=INIT_Y<<FRAC_BITS,
//   yspeed=0, state AIR, coyote counter 0. Inputs ignored except on startOfFrame cycles.
//  Positions/speeds: 32-bit signed regs. Outputs registered; change the cycle after startOfFrame.
//  X (per frame): right&!left -> +X_SPEED; left&!right -> -X_SPEED; both/none -> 0.
//   collision&HitEdgeCode[1] zeroes +speed; collision&HitEdgeCode[3] zeroes -speed.
//   x_fp += xspeed, then integer part clamped to [X_MIN,X_MAX] (fraction cleared on clamp).
//  Y: y_fp += yspeed (value held BEFORE this frame's update); then state/speed update:
//   footing = onBlock & HitEdgeCode[0].
//   AIR: if footing & yspeed>=0 -> GROUND, yspeed=0, y_fp fraction cleared.
//        elif onRope & (up|down) -> CLIMB. elif collision&HitEdgeCode[2]&yspeed<0 -> yspeed=0.
//        else yspeed=min(yspeed+GRAVITY, MAX_FALL).
//   GROUND: up -> AIR, yspeed=-JUMP_SPEED (jump beats rope). elif onRope&down -> CLIMB.
//        elif !footing -> AIR, yspeed=0. else yspeed=0.
//   CLIMB: !onRope -> AIR, yspeed=0. else up&!down -> -CLIMB_SPEED; down&!up -> +CLIMB_SPEED;
//        else 0. footing & down -> GROUND, yspeed=0. X movement still allowed.
//  Priority within a frame: reset > clamp/landing > jump > climb > gravity.
//  Encoding 11 unreachable; if seen, next frame forces AIR.
// CONFIGURATION
//  COYOTE_EN defined: GROUND->AIR via lost footing loads counter=COYOTE_FRAMES; each AIR frame
//   decrements; up while counter>0 in AIR -> yspeed=-JUMP_SPEED, counter=0. Landing clears it.
//  COYOTE_EN undefined: no counter; up in AIR is ignored.
// TESTING
//  Reset -> topLeftX=280, topLeftY=185, motionState=00, yVelocity=0 before any frame.
//  Right held 64 frames, no collision -> topLeftX=480; left+right both held -> X unchanged.
//  X=560, right held 10 frames -> topLeftX stops at 570, never 571; left from X=-5 stops at -9.
//  AIR from rest, no footing, 30 frames -> yVelocity 10,20..230 then stays 230.
//  GROUND, up pulse 1 frame -> state AIR, yVelocity=-300, next frame -290; Y falls back, lands, state 01.
//  COYOTE_EN: walk off block, up on 2nd AIR frame -> yVelocity=-300; up on 4th -> ignored (no macro: 1st ignored).

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-sprite motion engine.
// Fixed-point X/Y integration, gravity, jump, rope climb and horizontal screen clamp,
// organised around an AIR/GROUND/CLIMB state machine. State only advances on startOfFrame.
// Optional feature: define COYOTE_EN to allow a late jump for a few frames after
// walking off a block.
module sprite_motion_ctrl #(
  parameter int FRAC_BITS     = 6,
  parameter int INIT_X        = 280,
  parameter int INIT_Y        = 185,
  parameter int X_SPEED       = 200,
  parameter int GRAVITY       = 10,
  parameter int MAX_FALL      = 230,
  parameter int JUMP_SPEED    = 300,
  parameter int CLIMB_SPEED   = 100,
  parameter int X_MIN         = -9,
  parameter int X_MAX         = 570,
  parameter int COYOTE_FRAMES = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               leftPressed,
  input  logic               rightPressed,
  input  logic               upPressed,
  input  logic               downPressed,
  input  logic               collision,
  input  logic               onRope,
  input  logic               onBlock,
  input  logic [3:0]         HitEdgeCode,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [1:0]         motionState,
  output logic signed [11:0] yVelocity
);

  localparam int FpOne = 2 ** FRAC_BITS;
  localparam logic signed [31:0] XMinFp   = 32'(X_MIN * FpOne);
  localparam logic signed [31:0] XMaxFp   = 32'(X_MAX * FpOne);
  localparam logic signed [31:0] FracMask = 32'(FpOne - 1);

  typedef enum logic [1:0] {
    StAir    = 2'b00,
    StGround = 2'b01,
    StClimb  = 2'b10,
    StBad    = 2'b11
  } motion_e;

  motion_e            stateQ, stateD;
  logic signed [31:0] xFpQ, xFpD;
  logic signed [31:0] yFpQ, yFpD;
  logic signed [31:0] ySpeedQ, ySpeedD;
  logic signed [31:0] xSpeed, xSum, xInt;
  logic signed [31:0] yAdv, yFall;
  logic               footing;
`ifdef COYOTE_EN
  logic [7:0]         coyoteQ, coyoteD;
`endif

  // Horizontal speed from keys, blocked by side collisions, then integrate and clamp.
  always_comb begin
    xSpeed = '0;
    if (rightPressed && !leftPressed) begin
      xSpeed = X_SPEED;
    end else if (leftPressed && !rightPressed) begin
      xSpeed = -X_SPEED;
    end
    if (collision && HitEdgeCode[1] && xSpeed > 0) xSpeed = '0;
    if (collision && HitEdgeCode[3] && xSpeed < 0) xSpeed = '0;
    xSum = xFpQ + xSpeed;
    xInt = xSum >>> FRAC_BITS;
    xFpD = xSum;
    if (xInt < X_MIN) begin
      xFpD = XMinFp;
    end else if (xInt > X_MAX) begin
      xFpD = XMaxFp;
    end
  end

  // Vertical integration uses the speed held before this frame; state/speed update follows.
  always_comb begin
    footing = onBlock && HitEdgeCode[0];
    yAdv    = yFpQ + ySpeedQ;
    yFall   = (ySpeedQ + GRAVITY > MAX_FALL) ? MAX_FALL : ySpeedQ + GRAVITY;
    stateD  = stateQ;
    ySpeedD = ySpeedQ;
    yFpD    = yAdv;
`ifdef COYOTE_EN
    coyoteD = '0;
`endif
    unique case (stateQ)
      StAir: begin
`ifdef COYOTE_EN
        coyoteD = (coyoteQ != 8'd0) ? coyoteQ - 8'd1 : 8'd0;
`endif
        if (footing && ySpeedQ >= 0) begin
          stateD  = StGround;
          ySpeedD = '0;
          yFpD    = yAdv & ~FracMask;
`ifdef COYOTE_EN
          coyoteD = '0;
        end else if (upPressed && coyoteQ != 8'd0) begin
          ySpeedD = -JUMP_SPEED;
          coyoteD = '0;
`endif
        end else if (onRope && (upPressed || downPressed)) begin
          stateD = StClimb;
        end else if (collision && HitEdgeCode[2] && ySpeedQ < 0) begin
          ySpeedD = '0;
        end else begin
          ySpeedD = yFall;
        end
      end
      StGround: begin
        ySpeedD = '0;
        if (upPressed) begin
          stateD  = StAir;
          ySpeedD = -JUMP_SPEED;
        end else if (onRope && downPressed) begin
          stateD = StClimb;
        end else if (!footing) begin
          stateD = StAir;
`ifdef COYOTE_EN
          coyoteD = 8'(COYOTE_FRAMES);
`endif
        end
      end
      StClimb: begin
        if (!onRope) begin
          stateD  = StAir;
          ySpeedD = '0;
        end else begin
          if (upPressed && !downPressed) begin
            ySpeedD = -CLIMB_SPEED;
          end else if (downPressed && !upPressed) begin
            ySpeedD = CLIMB_SPEED;
          end else begin
            ySpeedD = '0;
          end
          if (footing && downPressed) begin
            stateD  = StGround;
            ySpeedD = '0;
          end
        end
      end
      StBad: begin
        // Unreachable encoding: recover to AIR at rest.
        stateD  = StAir;
        ySpeedD = '0;
      end
    endcase
  end

  // Motion registers; only a startOfFrame cycle commits a new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      xFpQ    <= 32'(INIT_X * FpOne);
      yFpQ    <= 32'(INIT_Y * FpOne);
      ySpeedQ <= '0;
      stateQ  <= StAir;
`ifdef COYOTE_EN
      coyoteQ <= '0;
`endif
    end else if (startOfFrame) begin
      xFpQ    <= xFpD;
      yFpQ    <= yFpD;
      ySpeedQ <= ySpeedD;
      stateQ  <= stateD;
`ifdef COYOTE_EN
      coyoteQ <= coyoteD;
`endif
    end
  end

  // Integer pixel position is the floor of the fixed-point value.
  assign topLeftX    = xFpQ[FRAC_BITS +: 11];
  assign topLeftY    = yFpQ[FRAC_BITS +: 11];
  assign motionState = stateQ;
  assign yVelocity   = ySpeedQ[11:0];

endmodule
